// File: rtl/dfd_mmrs.sv
// DFD memory-mapped register block: APB slave holding MCR/TR/NTR/DST/CLA CSRs,
// with hardware write-back ports and an external pass-through mode.
package dfd_mmrs_pkg;
    localparam int DFD_APB_ADDR_WIDTH  = 23;
    localparam int DFD_APB_DATA_WIDTH  = 64;
    localparam int DFD_APB_PSTRB_WIDTH = 8;
    localparam int DFD_MAX_INST        = 2;
    localparam int DFD_INST_IDX_W      = 1;

    localparam logic [11:0] MCR_CTRL_OFFSET   = 12'h000;
    localparam logic [11:0] MCR_STATUS_OFFSET = 12'h008;
    localparam logic [11:0] TR_CTRL_OFFSET    = 12'h000;
    localparam logic [11:0] TR_RAMDATA_OFFSET = 12'h008;
    localparam logic [11:0] NTR_CTRL_OFFSET   = 12'h000;
    localparam logic [11:0] DST_CTRL_OFFSET   = 12'h000;
    localparam logic [11:0] CLA_CTRL_OFFSET   = 12'h000;

    // MCR_CTRL is cold/sticky, MCR_STATUS is warm-override, the rest use reset_n.
    localparam logic [63:0] MCR_CTRL_RESET    = 64'h0000_0000_0000_0100;
    localparam logic [63:0] MCR_CTRL_RW       = 64'h00FF_FFFF_FFFF_FF0F;
    localparam logic [31:0] MCR_STATUS_RESET  = 32'h0000_0000;
    localparam logic [63:0] MCR_STATUS_W1C    = 64'h0000_0000_0000_00FF;
    localparam logic [31:0] TR_CTRL_RESET     = 32'h0000_0001;
    localparam logic [63:0] TR_CTRL_RW        = 64'h0000_0000_0000_FFFF;
    localparam logic [31:0] TR_RAMDATA_RESET  = 32'h0000_0000;
    localparam logic [31:0] NTR_CTRL_RESET    = 32'h0000_0010;
    localparam logic [63:0] NTR_CTRL_RW       = 64'h0000_0000_FFFF_FFFF;
    localparam logic [31:0] DST_CTRL_RESET    = 32'h0000_0000;
    localparam logic [63:0] DST_CTRL_RW       = 64'h0000_0000_0000_00FF;
    localparam logic [63:0] CLA_CTRL_RESET    = 64'h0000_0000_0000_0000;
    localparam logic [63:0] CLA_CTRL_RW       = 64'hFFFF_FFFF_FFFF_FFFF;

    typedef struct packed {
        logic        wr_en;
        logic [31:0] data;
    } hw32_s;

    typedef struct packed {
        logic [63:0]                   mcr_ctrl;
        logic [31:0]                   mcr_status;
        logic [31:0]                   ntr_ctrl;
        logic [DFD_MAX_INST-1:0][31:0] tr_ctrl;
        logic [DFD_MAX_INST-1:0][31:0] tr_ramdata;
        logic [DFD_MAX_INST-1:0][31:0] dst_ctrl;
        logic [DFD_MAX_INST-1:0][63:0] cla_ctrl;
    } DfdCsrs_s;

    typedef struct packed {
        hw32_s                    mcr_status;
        hw32_s [DFD_MAX_INST-1:0] tr_ramdata;
    } DfdCsrsWr_s;
endpackage

module dfd_mmrs
    import dfd_mmrs_pkg::*;
#(
    parameter int          INTERNAL_MMRS               = 1,
    parameter int          NTRACE_SUPPORT              = 1,
    parameter int          DST_SUPPORT                 = 1,
    parameter int          CLA_SUPPORT                 = 1,
    parameter int          NUM_TRACE_AND_ANALYZER_INST = 1,
    parameter logic [22:0] BASE_ADDR                   = 23'h0
) (
    input  logic                           clk,
    input  logic                           reset_n,
    input  logic                           reset_n_warm_ovrride,
    input  logic                           cold_reset_n,
    output DfdCsrs_s                       DfdCsrs,
    input  DfdCsrsWr_s                     DfdCsrsWr,
    input  DfdCsrs_s                       DfdCsrs_external,
    output DfdCsrsWr_s                     DfdCsrsWr_external,
    input  logic [DFD_APB_ADDR_WIDTH-1:0]  paddr,
    input  logic                           psel,
    input  logic                           penable,
    input  logic                           pwrite,
    input  logic [DFD_APB_PSTRB_WIDTH-1:0] pstrb,
    input  logic [DFD_APB_DATA_WIDTH-1:0]  pwdata,
    output logic [DFD_APB_DATA_WIDTH-1:0]  prdata,
    output logic                           pready,
    output logic                           pslverr
);
    logic                          access, wr, below, mapped, err;
    logic [22:0]                   offset;
    logic [3:0]                    inst, unit;
    logic [11:0]                   roff;
    logic [DFD_INST_IDX_W-1:0]     iidx;
    logic [63:0]                   bm, rdata, upd;
    logic                          inst_hit;
    DfdCsrs_s                      csr_int;

    logic [63:0]                   mcr_ctrl_q, mcr_ctrl_d;
    logic [31:0]                   mcr_status_q, mcr_status_d, ntr_ctrl_q, ntr_ctrl_d;
    logic [DFD_MAX_INST-1:0][31:0] tr_ctrl_q, tr_ctrl_d, tr_ramdata_q, tr_ramdata_d;
    logic [DFD_MAX_INST-1:0][31:0] dst_ctrl_q, dst_ctrl_d;
    logic [DFD_MAX_INST-1:0][63:0] cla_ctrl_q, cla_ctrl_d;

    // HW write loads first; APB then overrides only its strobed writable/W1C bits.
    function automatic logic [63:0] csr_update(input logic [63:0] cur, input logic hw_en,
                                               input logic [63:0] hw_data, input logic we,
                                               input logic [63:0] bmask, input logic [63:0] wdata,
                                               input logic [63:0] rw_mask, input logic [63:0] w1c_mask);
        logic [63:0] res, rw, clr;
        res = hw_en ? hw_data : cur;
        rw  = we ? (bmask & rw_mask) : 64'h0;
        clr = we ? (bmask & w1c_mask) : 64'h0;
        res = (res & ~rw) | (wdata & rw);
        res = (res & ~clr) | (cur & ~wdata & clr);
        return res;
    endfunction

    assign access = psel & penable & reset_n;
    assign {below, offset} = {1'b0, paddr} - {1'b0, BASE_ADDR};
    assign inst = offset[19:16];
    assign unit = offset[15:12];
    assign roff = offset[11:0];
    assign iidx = inst[DFD_INST_IDX_W-1:0];

    always_comb begin
        for (int i = 0; i < DFD_APB_PSTRB_WIDTH; i++) begin
            bm[8*i +: 8] = {8{pstrb[i]}};
        end
    end

    always_comb begin
        mapped = 1'b0;
        rdata  = '0;
        if (offset[22:20] == 3'd0 && int'(inst) < NUM_TRACE_AND_ANALYZER_INST) begin
            case (unit)
                4'd0: if (inst == 4'd0) begin
                    if (roff == MCR_CTRL_OFFSET) begin
                        mapped = 1'b1; rdata = mcr_ctrl_q;
                    end else if (roff == MCR_STATUS_OFFSET) begin
                        mapped = 1'b1; rdata = {32'h0, mcr_status_q};
                    end
                end
                4'd1: if (roff == TR_CTRL_OFFSET) begin
                    mapped = 1'b1; rdata = {32'h0, tr_ctrl_q[iidx]};
                end else if (roff == TR_RAMDATA_OFFSET) begin
                    mapped = 1'b1; rdata = {32'h0, tr_ramdata_q[iidx]};
                end
                4'd2: if (inst == 4'd0 && NTRACE_SUPPORT != 0 && roff == NTR_CTRL_OFFSET) begin
                    mapped = 1'b1; rdata = {32'h0, ntr_ctrl_q};
                end
                4'd3: if (DST_SUPPORT != 0 && roff == DST_CTRL_OFFSET) begin
                    mapped = 1'b1; rdata = {32'h0, dst_ctrl_q[iidx]};
                end
                4'd4: if (CLA_SUPPORT != 0 && roff == CLA_CTRL_OFFSET) begin
                    mapped = 1'b1; rdata = cla_ctrl_q[iidx];
                end
                default: ;
            endcase
        end
    end

    assign err     = below || (paddr[2:0] != 3'd0) || !mapped || (INTERNAL_MMRS == 0);
    assign wr      = access & pwrite & ~err;
    assign pready  = access;
    assign pslverr = access & err;
    assign prdata  = (access && !err) ? rdata : 64'h0;

    always_comb begin
        upd      = '0;
        inst_hit = 1'b0;
        mcr_ctrl_d = csr_update(mcr_ctrl_q, 1'b0, 64'h0, wr && unit == 4'd0 && roff == MCR_CTRL_OFFSET,
                                bm, pwdata, MCR_CTRL_RW, 64'h0);
        upd = csr_update(64'(mcr_status_q), DfdCsrsWr.mcr_status.wr_en, 64'(DfdCsrsWr.mcr_status.data),
                         wr && unit == 4'd0 && roff == MCR_STATUS_OFFSET, bm, pwdata, 64'h0, MCR_STATUS_W1C);
        mcr_status_d = upd[31:0];
        upd = csr_update(64'(ntr_ctrl_q), 1'b0, 64'h0, wr && unit == 4'd2, bm, pwdata, NTR_CTRL_RW, 64'h0);
        ntr_ctrl_d = upd[31:0];
        for (int i = 0; i < DFD_MAX_INST; i++) begin
            inst_hit = wr && (int'(inst) == i);
            upd = csr_update(64'(tr_ctrl_q[i]), 1'b0, 64'h0, inst_hit && unit == 4'd1 && roff == TR_CTRL_OFFSET,
                             bm, pwdata, TR_CTRL_RW, 64'h0);
            tr_ctrl_d[i] = upd[31:0];
            upd = csr_update(64'(tr_ramdata_q[i]), DfdCsrsWr.tr_ramdata[i].wr_en && i < NUM_TRACE_AND_ANALYZER_INST,
                             64'(DfdCsrsWr.tr_ramdata[i].data), 1'b0, bm, pwdata, 64'h0, 64'h0);
            tr_ramdata_d[i] = upd[31:0];
            upd = csr_update(64'(dst_ctrl_q[i]), 1'b0, 64'h0, inst_hit && unit == 4'd3, bm, pwdata, DST_CTRL_RW, 64'h0);
            dst_ctrl_d[i] = upd[31:0];
            cla_ctrl_d[i] = csr_update(cla_ctrl_q[i], 1'b0, 64'h0, inst_hit && unit == 4'd4, bm, pwdata,
                                       CLA_CTRL_RW, 64'h0);
        end
    end

    always_ff @(posedge clk or negedge cold_reset_n) begin
        if (!cold_reset_n) mcr_ctrl_q <= MCR_CTRL_RESET;
        else               mcr_ctrl_q <= mcr_ctrl_d;
    end

    always_ff @(posedge clk or negedge reset_n_warm_ovrride) begin
        if (!reset_n_warm_ovrride) mcr_status_q <= MCR_STATUS_RESET;
        else                       mcr_status_q <= mcr_status_d;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ntr_ctrl_q <= NTR_CTRL_RESET;
            for (int i = 0; i < DFD_MAX_INST; i++) begin
                tr_ctrl_q[i]    <= TR_CTRL_RESET;
                tr_ramdata_q[i] <= TR_RAMDATA_RESET;
                dst_ctrl_q[i]   <= DST_CTRL_RESET;
                cla_ctrl_q[i]   <= CLA_CTRL_RESET;
            end
        end else begin
            ntr_ctrl_q   <= ntr_ctrl_d;
            tr_ctrl_q    <= tr_ctrl_d;
            tr_ramdata_q <= tr_ramdata_d;
            dst_ctrl_q   <= dst_ctrl_d;
            cla_ctrl_q   <= cla_ctrl_d;
        end
    end

    always_comb begin
        csr_int            = '0;
        csr_int.mcr_ctrl   = mcr_ctrl_q;
        csr_int.mcr_status = mcr_status_q;
        csr_int.ntr_ctrl   = ntr_ctrl_q;
        csr_int.tr_ctrl    = tr_ctrl_q;
        csr_int.tr_ramdata = tr_ramdata_q;
        csr_int.dst_ctrl   = dst_ctrl_q;
        csr_int.cla_ctrl   = cla_ctrl_q;
    end

    assign DfdCsrs            = (INTERNAL_MMRS != 0) ? csr_int : DfdCsrs_external;
    assign DfdCsrsWr_external = (INTERNAL_MMRS != 0) ? '0 : DfdCsrsWr;
endmodule

// File: tb/tb_dfd_mmrs.sv
// Directed bench for dfd_mmrs: default build, a CLA-less build and an external-storage build
// share one APB bus and reset set.
module tb_dfd_mmrs;
    import dfd_mmrs_pkg::*;

    logic        clk = 1'b0;
    logic        reset_n, warm_n, cold_n;
    logic [22:0] paddr;
    logic        psel, penable, pwrite;
    logic [7:0]  pstrb;
    logic [63:0] pwdata;
    logic [63:0] prdata1, prdata2, prdata3;
    logic        pready1, pready2, pready3, pslverr1, pslverr2, pslverr3;
    DfdCsrs_s    csrs1, csrs2, csrs3, csrs_ext;
    DfdCsrsWr_s  csrs_wr, wr_ext1, wr_ext2, wr_ext3;

    logic [63:0] r_data1, r_data2, r_data3;
    logic        r_err1, r_err2, r_err3, r_rdy1, r_rdy2, r_rdy3;
    int          total = 0;
    int          bad   = 0;

    always #5 clk = ~clk;

    dfd_mmrs dut1 (
        .clk(clk), .reset_n(reset_n), .reset_n_warm_ovrride(warm_n), .cold_reset_n(cold_n),
        .DfdCsrs(csrs1), .DfdCsrsWr(csrs_wr), .DfdCsrs_external(csrs_ext), .DfdCsrsWr_external(wr_ext1),
        .paddr(paddr), .psel(psel), .penable(penable), .pwrite(pwrite), .pstrb(pstrb), .pwdata(pwdata),
        .prdata(prdata1), .pready(pready1), .pslverr(pslverr1));

    dfd_mmrs #(.CLA_SUPPORT(0)) dut2 (
        .clk(clk), .reset_n(reset_n), .reset_n_warm_ovrride(warm_n), .cold_reset_n(cold_n),
        .DfdCsrs(csrs2), .DfdCsrsWr(csrs_wr), .DfdCsrs_external(csrs_ext), .DfdCsrsWr_external(wr_ext2),
        .paddr(paddr), .psel(psel), .penable(penable), .pwrite(pwrite), .pstrb(pstrb), .pwdata(pwdata),
        .prdata(prdata2), .pready(pready2), .pslverr(pslverr2));

    dfd_mmrs #(.INTERNAL_MMRS(0)) dut3 (
        .clk(clk), .reset_n(reset_n), .reset_n_warm_ovrride(warm_n), .cold_reset_n(cold_n),
        .DfdCsrs(csrs3), .DfdCsrsWr(csrs_wr), .DfdCsrs_external(csrs_ext), .DfdCsrsWr_external(wr_ext3),
        .paddr(paddr), .psel(psel), .penable(penable), .pwrite(pwrite), .pstrb(pstrb), .pwdata(pwdata),
        .prdata(prdata3), .pready(pready3), .pslverr(pslverr3));

    // One full setup+access transfer; outputs captured mid access phase.
    task automatic apb(input logic wr, input logic [22:0] addr, input logic [63:0] data, input logic [7:0] strb);
        @(posedge clk); #1;
        psel = 1'b1; penable = 1'b0; pwrite = wr; paddr = addr; pwdata = data; pstrb = strb;
        @(posedge clk); #1;
        penable = 1'b1;
        #3;
        r_data1 = prdata1; r_err1 = pslverr1; r_rdy1 = pready1;
        r_data2 = prdata2; r_err2 = pslverr2; r_rdy2 = pready2;
        r_data3 = prdata3; r_err3 = pslverr3; r_rdy3 = pready3;
        @(posedge clk); #1;
        psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
    endtask

    task automatic test_reset();
        logic [22:0] addrs [7];
        logic [63:0] exps  [7];
        addrs = '{23'h0000, 23'h0008, 23'h1000, 23'h1008, 23'h2000, 23'h3000, 23'h4000};
        exps  = '{64'h100, 64'h0, 64'h1, 64'h0, 64'h10, 64'h0, 64'h0};
        reset_n = 1'b0; warm_n = 1'b0; cold_n = 1'b0;
        psel = 1'b1; penable = 1'b1; pwrite = 1'b0; paddr = '0; pstrb = '0; pwdata = '0;
        csrs_wr = '0; csrs_ext = '0;
        #22;
        total++;
        if (pready1 !== 1'b0 || pslverr1 !== 1'b0 || prdata1 !== 64'h0) begin
            bad++; $display("[TB] FAIL reset_outputs: got rdy=%b err=%b data=%h required 0/0/0", pready1, pslverr1, prdata1);
        end
        psel = 1'b0; penable = 1'b0;
        reset_n = 1'b1; warm_n = 1'b1; cold_n = 1'b1;
        for (int i = 0; i < 7; i++) begin
            apb(1'b0, addrs[i], 64'h0, 8'h00);
            total++;
            if (r_data1 !== exps[i] || r_err1 !== 1'b0 || r_rdy1 !== 1'b1) begin
                bad++; $display("[TB] FAIL reset_value[%0d]: got %h err=%b rdy=%b required %h err=0 rdy=1", i, r_data1, r_err1, r_rdy1, exps[i]);
            end
        end
        total++;
        if (csrs1.tr_ctrl[0] !== 32'h1 || csrs1.mcr_ctrl !== 64'h100) begin
            bad++; $display("[TB] FAIL reset_struct: got tr=%h mcr=%h required 1 / 100", csrs1.tr_ctrl[0], csrs1.mcr_ctrl);
        end
    endtask

    task automatic test_mcr_write();
        apb(1'b1, 23'h0000, 64'hA5A5_5A5A_1234_5678, 8'hFF);
        apb(1'b0, 23'h0000, 64'h0, 8'h00);
        total++;
        if (r_data1 !== 64'h00A5_5A5A_1234_5608) begin
            bad++; $display("[TB] FAIL mcr_full_write: got %h required 00a55a5a12345608", r_data1);
        end
        apb(1'b1, 23'h0000, 64'h1111_2222_3333_4444, 8'h0F);
        apb(1'b0, 23'h0000, 64'h0, 8'h00);
        total++;
        if (r_data1 !== 64'h00A5_5A5A_3333_4404) begin
            bad++; $display("[TB] FAIL mcr_low_strobe: got %h required 00a55a5a33334404", r_data1);
        end
        apb(1'b1, 23'h0000, 64'hFFFF_FFFF_FFFF_FFFF, 8'h00);
        total++;
        if (r_err1 !== 1'b0 || csrs1.mcr_ctrl !== 64'h00A5_5A5A_3333_4404) begin
            bad++; $display("[TB] FAIL mcr_zero_strobe: got err=%b val=%h required 0 / 00a55a5a33334404", r_err1, csrs1.mcr_ctrl);
        end
    endtask

    task automatic test_hw_write();
        @(posedge clk); #1;
        csrs_wr.tr_ramdata[0].wr_en = 1'b1; csrs_wr.tr_ramdata[0].data = 32'hCEED1020;
        @(posedge clk); #1;
        csrs_wr.tr_ramdata[0].wr_en = 1'b0; csrs_wr.tr_ramdata[0].data = 32'h0;
        total++;
        if (csrs1.tr_ramdata[0] !== 32'hCEED1020) begin
            bad++; $display("[TB] FAIL hw_struct: got %h required ceed1020", csrs1.tr_ramdata[0]);
        end
        apb(1'b1, 23'h1008, 64'hFFFF_FFFF_FFFF_FFFF, 8'hFF);
        apb(1'b0, 23'h1008, 64'h0, 8'h00);
        total++;
        if (r_data1 !== 64'h0000_0000_CEED_1020 || r_err1 !== 1'b0) begin
            bad++; $display("[TB] FAIL hw_ramdata_read: got %h err=%b required 00000000ceed1020 err=0", r_data1, r_err1);
        end
    endtask

    task automatic test_w1c();
        @(posedge clk); #1;
        csrs_wr.mcr_status.wr_en = 1'b1; csrs_wr.mcr_status.data = 32'h0000_A5F3;
        @(posedge clk); #1;
        csrs_wr.mcr_status = '0;
        apb(1'b1, 23'h0008, 64'h0000_0000_0000_FF03, 8'hFF);
        apb(1'b0, 23'h0008, 64'h0, 8'h00);
        total++;
        if (r_data1 !== 64'h0000_0000_0000_A5F0) begin
            bad++; $display("[TB] FAIL w1c_clear: got %h required 000000000000a5f0", r_data1);
        end
    endtask

    task automatic test_back_to_back_collision();
        @(posedge clk); #1;
        psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 23'h0008; pwdata = 64'h30; pstrb = 8'h01;
        @(posedge clk); #1;
        penable = 1'b1;
        csrs_wr.mcr_status.wr_en = 1'b1; csrs_wr.mcr_status.data = 32'h1234_56FF;
        @(posedge clk); #1;
        psel = 1'b0; penable = 1'b0; pwrite = 1'b0; csrs_wr.mcr_status = '0;
        apb(1'b0, 23'h0008, 64'h0, 8'h00);
        total++;
        if (r_data1 !== 64'h0000_0000_1234_56C0) begin
            bad++; $display("[TB] FAIL collision: got %h required 00000000123456c0", r_data1);
        end
    endtask

    task automatic test_errors();
        logic [22:0] addrs [5];
        addrs = '{23'h0010, 23'h0004, 23'h1_1000, 23'h5000, 23'h10_0000};
        for (int i = 0; i < 5; i++) begin
            apb(1'b1, addrs[i], 64'hFFFF_FFFF_FFFF_FFFF, 8'hFF);
            total++;
            if (r_err1 !== 1'b1 || r_data1 !== 64'h0 || r_rdy1 !== 1'b1) begin
                bad++; $display("[TB] FAIL err_write[%0d]: got err=%b data=%h rdy=%b required 1/0/1", i, r_err1, r_data1, r_rdy1);
            end
            apb(1'b0, addrs[i], 64'h0, 8'h00);
            total++;
            if (r_err1 !== 1'b1 || r_data1 !== 64'h0) begin
                bad++; $display("[TB] FAIL err_read[%0d]: got err=%b data=%h required 1/0", i, r_err1, r_data1);
            end
        end
        total++;
        if (csrs1.mcr_ctrl !== 64'h00A5_5A5A_3333_4404 || csrs1.tr_ctrl[0] !== 32'h1 || csrs1.tr_ctrl[1] !== 32'h1) begin
            bad++; $display("[TB] FAIL err_no_change: got mcr=%h tr0=%h tr1=%h", csrs1.mcr_ctrl, csrs1.tr_ctrl[0], csrs1.tr_ctrl[1]);
        end
    endtask

    task automatic test_cla_disabled();
        apb(1'b1, 23'h4000, 64'hFFFF_FFFF_FFFF_FFFF, 8'hFF);
        apb(1'b0, 23'h4000, 64'h0, 8'h00);
        total++;
        if (r_err2 !== 1'b1 || r_data2 !== 64'h0 || r_rdy2 !== 1'b1 || csrs2.cla_ctrl[0] !== 64'h0) begin
            bad++; $display("[TB] FAIL cla_disabled: got err=%b data=%h rdy=%b reg=%h required 1/0/1/0", r_err2, r_data2, r_rdy2, csrs2.cla_ctrl[0]);
        end
        total++;
        if (r_err1 !== 1'b0 || r_data1 !== 64'hFFFF_FFFF_FFFF_FFFF) begin
            bad++; $display("[TB] FAIL cla_enabled: got err=%b data=%h required 0/ffffffffffffffff", r_err1, r_data1);
        end
    endtask

    task automatic test_external();
        csrs_ext.mcr_ctrl    = 64'h0123_4567_89AB_CDEF;
        csrs_ext.cla_ctrl[1] = 64'hFEDC_BA98_7654_3210;
        csrs_wr.tr_ramdata[1].wr_en = 1'b1; csrs_wr.tr_ramdata[1].data = 32'h5555_AAAA;
        #1;
        total++;
        if (csrs3.mcr_ctrl !== 64'h0123_4567_89AB_CDEF || csrs3.cla_ctrl[1] !== 64'hFEDC_BA98_7654_3210) begin
            bad++; $display("[TB] FAIL ext_mirror: got %h %h", csrs3.mcr_ctrl, csrs3.cla_ctrl[1]);
        end
        total++;
        if (wr_ext3.tr_ramdata[1].wr_en !== 1'b1 || wr_ext3.tr_ramdata[1].data !== 32'h5555_AAAA) begin
            bad++; $display("[TB] FAIL ext_wr_forward: got en=%b data=%h required 1/5555aaaa", wr_ext3.tr_ramdata[1].wr_en, wr_ext3.tr_ramdata[1].data);
        end
        total++;
        if (wr_ext1 !== '0 || wr_ext2 !== '0) begin
            bad++; $display("[TB] FAIL int_wr_zero: got %h %h required 0", wr_ext1, wr_ext2);
        end
        apb(1'b0, 23'h0000, 64'h0, 8'h00);
        total++;
        if (r_err3 !== 1'b1 || r_data3 !== 64'h0 || r_rdy3 !== 1'b1) begin
            bad++; $display("[TB] FAIL ext_apb: got err=%b data=%h rdy=%b required 1/0/1", r_err3, r_data3, r_rdy3);
        end
        total++;
        if (csrs1.tr_ramdata[1] !== 32'h0) begin
            bad++; $display("[TB] FAIL inst_gate: got %h required 0", csrs1.tr_ramdata[1]);
        end
        csrs_wr = '0;
    endtask

    task automatic test_reset_mid();
        apb(1'b1, 23'h1000, 64'h1234, 8'hFF);
        apb(1'b0, 23'h1000, 64'h0, 8'h00);
        total++;
        if (r_data1 !== 64'h1234) begin
            bad++; $display("[TB] FAIL tr_write: got %h required 1234", r_data1);
        end
        @(posedge clk); #1;
        psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 23'h1000; pwdata = 64'hDEAD_BEEF; pstrb = 8'hFF;
        @(posedge clk); #1;
        penable = 1'b1;
        #2 reset_n = 1'b0;
        #1;
        total++;
        if (pready1 !== 1'b0 || pslverr1 !== 1'b0 || prdata1 !== 64'h0) begin
            bad++; $display("[TB] FAIL mid_reset_outputs: got rdy=%b err=%b data=%h required 0/0/0", pready1, pslverr1, prdata1);
        end
        @(posedge clk); #1;
        psel = 1'b0; penable = 1'b0; pwrite = 1'b0; reset_n = 1'b1;
        apb(1'b0, 23'h1000, 64'h0, 8'h00);
        total++;
        if (r_data1 !== 64'h1) begin
            bad++; $display("[TB] FAIL mid_reset_abort: got %h required 1", r_data1);
        end
        total++;
        if (csrs1.mcr_ctrl !== 64'h00A5_5A5A_3333_4404 || csrs1.mcr_status !== 32'h1234_56C0) begin
            bad++; $display("[TB] FAIL mid_reset_domains: got mcr=%h st=%h", csrs1.mcr_ctrl, csrs1.mcr_status);
        end
    endtask

    task automatic test_reset_domains();
        apb(1'b1, 23'h1000, 64'hDEAD_BEEF, 8'hFF);
        @(posedge clk); #1 cold_n = 1'b0;
        #2 cold_n = 1'b1;
        apb(1'b0, 23'h0000, 64'h0, 8'h00);
        total++;
        if (r_data1 !== 64'h100 || csrs1.tr_ctrl[0] !== 32'h0000_BEEF || csrs1.mcr_status !== 32'h1234_56C0) begin
            bad++; $display("[TB] FAIL cold_only: got mcr=%h tr=%h st=%h required 100/beef/123456c0", r_data1, csrs1.tr_ctrl[0], csrs1.mcr_status);
        end
        @(posedge clk); #1 warm_n = 1'b0;
        #2 warm_n = 1'b1;
        apb(1'b0, 23'h0008, 64'h0, 8'h00);
        total++;
        if (r_data1 !== 64'h0 || csrs1.tr_ctrl[0] !== 32'h0000_BEEF || csrs1.mcr_ctrl !== 64'h100) begin
            bad++; $display("[TB] FAIL warm_only: got st=%h tr=%h mcr=%h required 0/beef/100", r_data1, csrs1.tr_ctrl[0], csrs1.mcr_ctrl);
        end
    endtask

    initial begin
        test_reset();
        test_mcr_write();
        test_hw_write();
        test_w1c();
        test_back_to_back_collision();
        test_errors();
        test_cla_disabled();
        test_external();
        test_reset_mid();
        test_reset_domains();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #100000;
        $display("[TB] FAIL timeout: got no finish required finish before 100000");
        $fatal(1, "[TB] timeout");
    end
endmodule
